// File: rtl/reorder_buffer_mc.sv
// Reorder buffer with in-order multi-lane commit, store throttling and
// branch/jump mispredict flush handshake.
module reorder_buffer_mc #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDW   = 4,
  parameter int unsigned CMT_W = 2,
  parameter int unsigned REGBW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  input  logic [2:0]              alloc_type,
  input  logic [REGBW-1:0]        alloc_des,
  input  logic [31:0]             alloc_prd_pc,
  output logic                    alloc_ready,
  output logic [IDW-1:0]          alloc_id,
  input  logic                    wb0_valid,
  input  logic [IDW-1:0]          wb0_id,
  input  logic [31:0]             wb0_val,
  input  logic [31:0]             wb0_rel_pc,
  input  logic                    wb1_valid,
  input  logic [IDW-1:0]          wb1_id,
  input  logic [31:0]             wb1_val,
  input  logic                    st_valid,
  input  logic [IDW-1:0]          st_id,
  output logic [CMT_W-1:0]        cmt_valid,
  output logic [CMT_W-1:0]        cmt_is_st,
  output logic [CMT_W*REGBW-1:0]  cmt_des,
  output logic [CMT_W*32-1:0]     cmt_val,
  output logic [CMT_W*IDW-1:0]    cmt_id,
  output logic                    flush_req,
  output logic [31:0]             flush_pc,
  input  logic                    flush_ack,
  input  logic [IDW-1:0]          q1_id,
  output logic                    q1_rdy,
  output logic [31:0]             q1_val,
  input  logic [IDW-1:0]          q2_id,
  output logic                    q2_rdy,
  output logic [31:0]             q2_val,
  output logic [IDW:0]            count
);
  localparam int unsigned PW = IDW + 1;
  localparam logic [2:0] T_BR  = 3'd1;
  localparam logic [2:0] T_JMP = 3'd2;
  localparam logic [2:0] T_ST  = 3'd4;

  typedef enum logic {S_RUN, S_FLUSH} state_t;
  state_t state_q, state_d;

  logic [DEPTH-1:0] busy_q, ready_q;
  logic [2:0]       type_q [DEPTH];
  logic [REGBW-1:0] des_q  [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [31:0]      prd_q  [DEPTH];
  logic [31:0]      rel_q  [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [IDW-1:0]   tail_idx;

  logic             do_alloc, wb0_hit, wb1_hit, st_hit;
  logic [CMT_W-1:0] go;
  logic [IDW-1:0]   lane_idx [CMT_W];
  logic             chain, st_seen, mispredict;
  logic [31:0]      mis_pc;
  logic [PW-1:0]    n_cmt;

  assign tail_idx = tail_q[IDW-1:0];
  assign do_alloc = rdy && alloc_valid && alloc_ready;
  assign wb0_hit  = rdy && (state_q == S_RUN) && wb0_valid && busy_q[wb0_id];
  assign wb1_hit  = rdy && (state_q == S_RUN) && wb1_valid && busy_q[wb1_id];
  assign st_hit   = rdy && (state_q == S_RUN) && st_valid  && busy_q[st_id];

  // Lane chain: a lane retires only if every lower lane retires and no
  // mispredict or second store sits below it.
  always_comb begin
    go         = '0;
    chain      = (state_q == S_RUN);
    st_seen    = 1'b0;
    mispredict = 1'b0;
    mis_pc     = '0;
    n_cmt      = '0;
    lane_idx   = '{default: '0};
    for (int unsigned k = 0; k < CMT_W; k++) begin
      lane_idx[k] = head_q[IDW-1:0] + IDW'(k);
      if (chain && busy_q[lane_idx[k]] && ready_q[lane_idx[k]] &&
          !(st_seen && type_q[lane_idx[k]] == T_ST)) begin
        go[k] = 1'b1;
        n_cmt = n_cmt + PW'(1);
        if (type_q[lane_idx[k]] == T_ST) st_seen = 1'b1;
        if ((type_q[lane_idx[k]] == T_BR || type_q[lane_idx[k]] == T_JMP) &&
            prd_q[lane_idx[k]] != rel_q[lane_idx[k]]) begin
          mispredict = 1'b1;
          mis_pc     = rel_q[lane_idx[k]];
          chain      = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (mispredict) state_d = S_FLUSH;
      S_FLUSH: if (flush_ack)  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    flush_req   = (state_q == S_FLUSH);
    alloc_ready = (count < PW'(DEPTH)) && (state_q == S_RUN);
    alloc_id    = tail_idx;
    q1_rdy      = ready_q[q1_id];
    q1_val      = val_q[q1_id];
    q2_rdy      = ready_q[q2_id];
    q2_val      = val_q[q2_id];
  end

  // Control state: occupancy bits, pointers, commit pulses and flush target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      ready_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count     <= '0;
      cmt_valid <= '0;
      cmt_is_st <= '0;
      flush_pc  <= '0;
    end else if (rdy) begin
      cmt_valid <= '0;
      cmt_is_st <= '0;
      if (state_q == S_FLUSH) begin
        if (flush_ack) begin
          busy_q  <= '0;
          ready_q <= '0;
          head_q  <= '0;
          tail_q  <= '0;
          count   <= '0;
        end
      end else begin
        if (wb0_hit) ready_q[wb0_id] <= 1'b1;
        if (wb1_hit) ready_q[wb1_id] <= 1'b1;
        if (st_hit)  ready_q[st_id]  <= 1'b1;
        for (int unsigned k = 0; k < CMT_W; k++) begin
          if (go[k]) begin
            busy_q[lane_idx[k]]  <= 1'b0;
            ready_q[lane_idx[k]] <= 1'b0;
            cmt_valid[k]         <= (type_q[lane_idx[k]] != T_BR);
            cmt_is_st[k]         <= (type_q[lane_idx[k]] == T_ST);
          end
        end
        if (do_alloc) begin
          busy_q[tail_idx]  <= 1'b1;
          ready_q[tail_idx] <= 1'b0;
          tail_q            <= tail_q + PW'(1);
        end
        head_q <= head_q + n_cmt;
        count  <= count + PW'(do_alloc) - n_cmt;
        if (mispredict) flush_pc <= mis_pc;
      end
    end
  end

  // Entry payload and commit data; meaningful only alongside the valid bits.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_alloc) begin
        type_q[tail_idx] <= alloc_type;
        des_q[tail_idx]  <= alloc_des;
        prd_q[tail_idx]  <= alloc_prd_pc;
        rel_q[tail_idx]  <= alloc_prd_pc;
        val_q[tail_idx]  <= '0;
      end
      if (wb0_hit) begin
        val_q[wb0_id] <= wb0_val;
        rel_q[wb0_id] <= wb0_rel_pc;
      end
      if (wb1_hit) val_q[wb1_id] <= wb1_val;
      for (int unsigned k = 0; k < CMT_W; k++) begin
        if (go[k]) begin
          cmt_des[k*REGBW +: REGBW] <= des_q[lane_idx[k]];
          cmt_val[k*32 +: 32]       <= val_q[lane_idx[k]];
          cmt_id[k*IDW +: IDW]      <= lane_idx[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: directed scenarios plus random
// traffic checked against a program-order queue model.
module tb_reorder_buffer_mc;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDW   = 4;
  localparam int unsigned CMT_W = 2;
  localparam int unsigned REGBW = 5;
  localparam logic [2:0] T_ALU = 3'd0, T_BR = 3'd1, T_JMP = 3'd2, T_LD = 3'd3, T_ST = 3'd4;

  logic clk = 1'b0;
  logic rst, rdy;
  logic alloc_valid; logic [2:0] alloc_type; logic [REGBW-1:0] alloc_des; logic [31:0] alloc_prd_pc;
  logic alloc_ready; logic [IDW-1:0] alloc_id;
  logic wb0_valid; logic [IDW-1:0] wb0_id; logic [31:0] wb0_val, wb0_rel_pc;
  logic wb1_valid; logic [IDW-1:0] wb1_id; logic [31:0] wb1_val;
  logic st_valid; logic [IDW-1:0] st_id;
  logic [CMT_W-1:0] cmt_valid, cmt_is_st;
  logic [CMT_W*REGBW-1:0] cmt_des; logic [CMT_W*32-1:0] cmt_val; logic [CMT_W*IDW-1:0] cmt_id;
  logic flush_req; logic [31:0] flush_pc; logic flush_ack;
  logic [IDW-1:0] q1_id, q2_id; logic q1_rdy, q2_rdy; logic [31:0] q1_val, q2_val;
  logic [IDW:0] count;

  reorder_buffer_mc #(.DEPTH(DEPTH), .IDW(IDW), .CMT_W(CMT_W), .REGBW(REGBW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_des(alloc_des),
    .alloc_prd_pc(alloc_prd_pc), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val), .wb0_rel_pc(wb0_rel_pc),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .st_valid(st_valid), .st_id(st_id),
    .cmt_valid(cmt_valid), .cmt_is_st(cmt_is_st), .cmt_des(cmt_des), .cmt_val(cmt_val), .cmt_id(cmt_id),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
    .q1_id(q1_id), .q1_rdy(q1_rdy), .q1_val(q1_val),
    .q2_id(q2_id), .q2_rdy(q2_rdy), .q2_val(q2_val),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] typ; logic [REGBW-1:0] des; logic [31:0] val;
    logic [31:0] prd; logic [31:0] rel; logic [IDW-1:0] id;
  } ent_t;

  ent_t exp_q[$];
  ent_t by_id [DEPTH];
  logic [IDW-1:0] pend[$];
  logic [IDW:0] m_tail;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit mis(input ent_t e);
    return (e.typ == T_BR || e.typ == T_JMP) && (e.prd != e.rel);
  endfunction

  task automatic skip_good_br;
    while (exp_q.size() > 0 && exp_q[0].typ == T_BR && !mis(exp_q[0])) void'(exp_q.pop_front());
  endtask

  // ---------------- monitor ----------------
  bit flush_prev = 1'b0;
  bit jmp_flush = 1'b0;
  logic [31:0] jmp_pc;

  task automatic check_commit(input int unsigned k);
    ent_t e;
    checks++;
    skip_good_br();
    if (exp_q.size() == 0 || jmp_flush || exp_q[0].typ == T_BR) begin
      errors++;
      $display("FAIL cmt_unexpected: lane=%0d actual_id=%0h required=none", k, cmt_id[k*IDW +: IDW]);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk("cmt_id", cmt_id[k*IDW +: IDW], e.id);
    chk("cmt_is_st", cmt_is_st[k], e.typ == T_ST);
    if (e.typ != T_ST) begin
      chk("cmt_des", cmt_des[k*REGBW +: REGBW], e.des);
      chk("cmt_val", cmt_val[k*32 +: 32], e.val);
    end
    if (mis(e)) begin jmp_flush = 1'b1; jmp_pc = e.rel; end
  endtask

  task automatic handle_flush;
    logic [31:0] want;
    bit have;
    have = 1'b0; want = '0;
    if (jmp_flush) begin want = jmp_pc; have = 1'b1; jmp_flush = 1'b0; end
    else begin
      skip_good_br();
      if (exp_q.size() > 0 && mis(exp_q[0])) begin want = exp_q[0].rel; have = 1'b1; end
    end
    if (have) chk("flush_pc", flush_pc, want);
    else begin
      checks++; errors++;
      $display("FAIL flush_unexpected: actual flush_pc=%0h required=no flush", flush_pc);
    end
    exp_q.delete();
  endtask

  initial begin
    bit en;
    forever begin
      @(posedge clk);
      en = rdy;
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); flush_prev = 1'b0; jmp_flush = 1'b0;
      end else begin
        if (en) begin
          for (int unsigned k = 0; k < CMT_W; k++) if (cmt_valid[k]) check_commit(k);
          if (cmt_is_st != '0) chk("one_store_per_cycle", cmt_is_st == 2'b11, 0);
          if (flush_req && flush_prev) chk("flush_no_cmt", cmt_valid, 0);
          if (flush_req && !flush_prev) handle_flush();
        end
        flush_prev = flush_req;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  task automatic clr_in;
    alloc_valid = 0; wb0_valid = 0; wb1_valid = 0; st_valid = 0; flush_ack = 0;
  endtask

  task automatic cyc;
    bit acked;
    acked = flush_req && flush_ack && rdy;
    @(posedge clk); #1;
    clr_in();
    if (acked) begin m_tail = '0; pend.delete(); end
  endtask

  task automatic alloc(input logic [2:0] typ, input logic [REGBW-1:0] des, input logic [31:0] val,
                       input logic [31:0] prd, input logic [31:0] rel);
    ent_t e;
    alloc_valid = 1; alloc_type = typ; alloc_des = des; alloc_prd_pc = prd;
    if (rdy && alloc_ready) begin
      chk("alloc_id", alloc_id, m_tail[IDW-1:0]);
      e = '{typ: typ, des: des, val: val, prd: prd, rel: rel, id: m_tail[IDW-1:0]};
      exp_q.push_back(e); by_id[e.id] = e; pend.push_back(e.id);
      m_tail++;
    end
  endtask

  task automatic wb_try(input logic [IDW-1:0] id, output bit ok);
    ent_t e;
    e = by_id[id]; ok = 1'b0;
    if (e.typ == T_ST) begin
      if (!st_valid) begin st_valid = 1; st_id = id; ok = 1'b1; end
    end else if (e.typ == T_BR || e.typ == T_JMP) begin
      if (!wb0_valid) begin wb0_valid = 1; wb0_id = id; wb0_val = e.val; wb0_rel_pc = e.rel; ok = 1'b1; end
    end else if (e.typ == T_LD && !wb1_valid) begin
      wb1_valid = 1; wb1_id = id; wb1_val = e.val; ok = 1'b1;
    end else if (!wb0_valid) begin
      wb0_valid = 1; wb0_id = id; wb0_val = e.val; wb0_rel_pc = $urandom; ok = 1'b1;
    end else if (!wb1_valid) begin
      wb1_valid = 1; wb1_id = id; wb1_val = e.val; ok = 1'b1;
    end
  endtask

  task automatic wb_id(input logic [IDW-1:0] id);
    bit ok;
    wb_try(id, ok);
    if (ok) for (int i = 0; i < pend.size(); i++) if (pend[i] == id) begin pend.delete(i); break; end
  endtask

  task automatic wb_some(input int unsigned pct);
    int i;
    bit ok;
    i = 0;
    while (i < pend.size()) begin
      ok = 1'b0;
      if ($urandom_range(99) < pct) wb_try(pend[i], ok);
      if (ok) pend.delete(i); else i++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || count != 0 || flush_req) && n < budget) begin
      rdy = 1;
      if (flush_req) flush_ack = 1; else wb_some(100);
      cyc(); n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic wait_flush(input string name);
    int n;
    n = 0;
    while (!flush_req && n < 20) begin cyc(); n++; end
    chk(name, flush_req, 1);
  endtask

  initial begin
    logic [2:0] typ;
    logic [31:0] prd, rel;
    int n, non_br;
    rst = 1; rdy = 1; clr_in(); q1_id = '0; q2_id = '0;
    alloc_type = '0; alloc_des = '0; alloc_prd_pc = '0;
    wb0_id = '0; wb0_val = '0; wb0_rel_pc = '0; wb1_id = '0; wb1_val = '0; st_id = '0;
    m_tail = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_cmt_valid", cmt_valid, 0);
    chk("rst_cmt_is_st", cmt_is_st, 0);
    chk("rst_flush_req", flush_req, 0);
    chk("rst_flush_pc", flush_pc, 0);

    // fill, reject at full, then two writebacks commit as a pair
    for (int i = 0; i < 16; i++) begin alloc(T_ALU, REGBW'(i), 32'h1000 + i, '0, '0); cyc(); end
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    alloc(T_ALU, 5'd31, 32'hdead, '0, '0);
    wb_id(4'd0); wb_id(4'd1);
    cyc();
    chk("full_hold_count", count, 16);
    cyc();
    chk("pair_cmt_valid", cmt_valid, 2'b11);
    chk("pair_cmt_id", cmt_id, 8'h10);
    chk("pair_count", count, 14);
    chk("pair_alloc_ready", alloc_ready, 1);
    drain("drain1", 100);

    // mispredicted branch at id 3 with a ready id 4 behind it
    for (int i = 0; i < 5; i++) begin
      if (i == 3) alloc(T_BR, 5'd0, '0, 32'h100, 32'h200);
      else alloc(T_ALU, REGBW'(i + 8), 32'h2000 + i, '0, '0);
      cyc();
    end
    wb_id(4'd0); wb_id(4'd1); cyc();
    wb_id(4'd2); cyc();
    wb_id(4'd3); wb_id(4'd4); cyc();
    wait_flush("br_flush_seen");
    chk("br_flush_pc", flush_pc, 32'h200);
    chk("br_lane_cmt", cmt_valid, 2'b00);
    cyc();
    chk("br_flush_hold", flush_req, 1);
    chk("br_flush_alloc_ready", alloc_ready, 0);
    flush_ack = 1; cyc();
    chk("ack_count", count, 0);
    chk("ack_alloc_id", alloc_id, 0);
    chk("ack_flush_req", flush_req, 0);
    chk("ack_alloc_ready", alloc_ready, 1);

    // two adjacent ready stores reach the head together
    alloc(T_ALU, 5'd1, 32'h11, '0, '0); cyc();
    alloc(T_ALU, 5'd2, 32'h22, '0, '0); cyc();
    alloc(T_ST, 5'd0, '0, '0, '0); cyc();
    alloc(T_ST, 5'd0, '0, '0, '0); cyc();
    wb_id(4'd2); cyc();
    wb_id(4'd3); cyc();
    wb_id(4'd0); wb_id(4'd1); cyc();
    cyc();
    chk("st_pre_valid", cmt_valid, 2'b11);
    cyc();
    chk("st1_valid", cmt_valid, 2'b01);
    chk("st1_is_st", cmt_is_st, 2'b01);
    chk("st1_id", cmt_id[IDW-1:0], 2);
    cyc();
    chk("st2_valid", cmt_valid, 2'b01);
    chk("st2_is_st", cmt_is_st, 2'b01);
    chk("st2_id", cmt_id[IDW-1:0], 3);

    // same-cycle wb0/wb1 to one id: wb1 value wins, no bypass
    alloc(T_ALU, 5'd4, 32'h44, '0, '0); cyc();
    alloc(T_ALU, 5'd5, 32'hBB, '0, '0); cyc();
    for (int i = 0; i < pend.size(); i++) if (pend[i] == 4'd5) begin pend.delete(i); break; end
    wb0_valid = 1; wb0_id = 4'd5; wb0_val = 32'hAA; wb0_rel_pc = '0;
    wb1_valid = 1; wb1_id = 4'd5; wb1_val = 32'hBB;
    q1_id = 4'd5; q2_id = 4'd4;
    #1 chk("q_no_bypass", q1_rdy, 0);
    cyc();
    chk("q1_rdy", q1_rdy, 1);
    chk("q1_val", q1_val, 32'hBB);
    chk("q2_rdy", q2_rdy, 0);
    drain("drain2", 100);

    // 40 alloc/commit pairs across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      wb_some(100);
      alloc(T_ALU, REGBW'(i), $urandom, '0, '0);
      cyc();
      chk("wrap_count_max", count <= 16, 1);
    end
    drain("drain3", 100);

    // random traffic with stalls, mispredicts and delayed acks
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(9) != 0);
      if (flush_req) begin
        if ($urandom_range(2) == 0) flush_ack = 1;
      end else if (rdy) begin
        wb_some(40);
        if ($urandom_range(3) != 0) begin
          typ = 3'($urandom_range(4));
          prd = $urandom;
          rel = ((typ == T_BR || typ == T_JMP) && $urandom_range(7) == 0) ? (prd ^ 32'h4) : prd;
          alloc(typ, REGBW'($urandom), $urandom, prd, rel);
        end
      end
      q1_id = IDW'($urandom); q2_id = IDW'($urandom);
      cyc();
    end
    drain("drain_random", 600);
    repeat (2) cyc();
    non_br = 0;
    foreach (exp_q[i]) if (exp_q[i].typ != T_BR) non_br++;
    chk("random_leftover", non_br, 0);
    chk("random_count", count, 0);

    // reset while a flush is pending
    alloc(T_BR, 5'd0, '0, 32'h300, 32'h400); cyc();
    wb_some(100); cyc();
    wait_flush("rst_flush_seen");
    #2 rst = 1;
    #1;
    chk("rstf_flush_req", flush_req, 0);
    chk("rstf_count", count, 0);
    chk("rstf_cmt_valid", cmt_valid, 0);
    @(posedge clk); #1 rst = 0;
    m_tail = '0; pend.delete();
    chk("rstf_alloc_ready", alloc_ready, 1);

    // reset while commits are being presented
    alloc(T_ALU, 5'd7, 32'h77, '0, '0); cyc();
    alloc(T_ALU, 5'd8, 32'h88, '0, '0); cyc();
    wb_some(100); cyc();
    n = 0;
    while (cmt_valid == '0 && n < 10) begin cyc(); n++; end
    chk("rstc_seen", cmt_valid != '0, 1);
    #2 rst = 1;
    #1;
    chk("rstc_cmt_valid", cmt_valid, 0);
    chk("rstc_count", count, 0);
    @(posedge clk); #1 rst = 0;
    m_tail = '0; pend.delete();
    cyc();
    chk("rstc_alloc_id", alloc_id, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
